mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter memory_width, default 32, data word width in bits.
REQ-002 SHALL have parameter memory_depth, default 1024, word-addressed depth; address width AW = $clog2(memory_depth) (10 at default).
REQ-003 SHALL have one clock, clk (input, 1), rising edge; reset is synchronous and active-low, named reset_n (input, 1).
REQ-004 SHALL have req_valid (input, 1): pipeline presents a request.
REQ-005 SHALL have req_ready (output, 1): queue can accept a request this cycle.
REQ-006 SHALL have req_we (input, 1): 1 = store, 0 = load.
REQ-007 SHALL have req_addr (input, AW): word address.
REQ-008 SHALL have req_wdata (input, memory_width): store data.
REQ-009 SHALL have resp_valid (output, 1): one-cycle completion pulse.
REQ-010 SHALL have resp_we (output, 1): completed access was a store.
REQ-011 SHALL have resp_rdata (output, memory_width): load data.
REQ-012 SHALL have RE and WE (outputs, 1 each): read and write enables to the memory system.
REQ-013 SHALL have A (output, AW) and WD (output, memory_width): memory-system address and write data.
REQ-014 SHALL have stall (input, 1) and RD (input, memory_width) from the memory system.
REQ-015 SHALL have stall_count (output, 16): saturating count of stalled access cycles.

Function
REQ-016 SHALL hold a 2-entry FIFO of {we, addr, wdata}; req_ready = (count < 2), registered-state only, with no same-cycle bypass when full.
REQ-017 SHALL push on the rising edge where req_valid && req_ready; a request accepted at edge N is presented to memory in the cycle after edge N.
REQ-018 SHALL drive, while FIFO non-empty (state ACCESS): RE = !head.we, WE = head.we, A = head.addr, WD = head.wdata; while empty (state IDLE): RE = WE = 0, A = 0, WD = 0.
REQ-019 SHALL treat an access as complete in any ACCESS cycle with stall == 0; it SHALL pop the head at that edge and capture RD into resp_rdata only when head is a load.
REQ-020 SHALL hold RE/WE/A/WD stable for every ACCESS cycle with stall == 1; the head SHALL NOT change while stalled.
REQ-021 SHALL pulse resp_valid for exactly one cycle after each completion edge, with resp_we = completed head.we; resp_rdata SHALL retain its previous value after a store.
REQ-022 SHALL sustain one completion per cycle on back-to-back non-stalled accesses (second entry driven the cycle after the first completes).
REQ-023 SHALL support push and pop on the same edge: count unchanged, ordering preserved; with count == 2, push is blocked (req_ready = 0) even if a pop occurs.
REQ-024 SHALL have two states: IDLE -> ACCESS when count becomes non-zero; ACCESS -> IDLE when the last entry pops with no concurrent push.
REQ-025 SHALL increment stall_count on every edge where (RE || WE) && stall, saturating at 16'hFFFF.
REQ-026 SHALL keep FIFO pointers 1 bit wide, wrapping 1 -> 0.

Reset
REQ-027 SHALL, on an edge with reset_n == 0, clear the FIFO (count 0), set state IDLE, resp_valid = 0, resp_we = 0, resp_rdata = 0, stall_count = 0; req_ready SHALL then be 1 and RE = WE = 0, A = 0, WD = 0.
REQ-028 SHALL discard any in-flight or queued access on reset mid-operation, with no resp_valid pulse for discarded entries.

Verification
REQ-029 SHALL be verified by: load addr 10'h005 with stall = 0 and RD = 32'hDEADBEEF -> RE = 1, A = 5 one cycle after accept; resp_valid = 1 and resp_rdata = DEADBEEF the cycle after that.
REQ-030 SHALL be verified by: store addr 10'h3FF, data 32'h12345678, stall held high 3 cycles -> WE/A/WD stable for 4 cycles, resp_valid = 1 and resp_we = 1 once, stall_count = 3, resp_rdata unchanged.
REQ-031 SHALL be verified by: 3 back-to-back req_valid with stall = 1 -> req_ready = 0 after the 2nd accept, 3rd accepted only after the first pop, responses in issue order.
REQ-032 SHALL be verified by: 2 queued loads, stall = 0 -> two consecutive resp_valid cycles with RD values in order.
REQ-033 SHALL be verified by: reset_n low during a stalled access with 2 entries -> RE = WE = 0, req_ready = 1, stall_count = 0, no resp_valid pulse.
REQ-034 SHALL be verified by: stall forced high for 70000 ACCESS cycles -> stall_count = 16'hFFFF, no wrap.

Source files
------------

// File: rtl/mem_requester_if.sv
// Pipeline-side request/response handshake plus the memory-system access bus.
// The slave modport is the requester's view; the master modport drives it.
interface mem_requester_if #(
  parameter int memory_width = 32,
  parameter int memory_depth = 1024
);
  localparam int AW = $clog2(memory_depth);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [AW-1:0]           req_addr;
  logic [memory_width-1:0] req_wdata;

  logic                    resp_valid;
  logic                    resp_we;
  logic [memory_width-1:0] resp_rdata;

  logic                    RE;
  logic                    WE;
  logic [AW-1:0]           A;
  logic [memory_width-1:0] WD;
  logic                    stall;
  logic [memory_width-1:0] RD;

  logic [15:0]             stall_count;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, stall, RD,
    output req_ready, resp_valid, resp_we, resp_rdata, RE, WE, A, WD, stall_count
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, stall, RD,
    input  req_ready, resp_valid, resp_we, resp_rdata, RE, WE, A, WD, stall_count
  );
endinterface

// File: rtl/mem_requester.sv
// Two-entry request queue in front of a stallable memory port. The head entry is
// driven to memory until a non-stalled cycle completes it.
module mem_requester #(
  parameter int memory_width = 32,
  parameter int memory_depth = 1024
) (
  input logic            clk,
  input logic            reset_n,
  mem_requester_if.slave bus
);
  localparam int AW = $clog2(memory_depth);

  typedef struct packed {
    logic                    we;
    logic [AW-1:0]           addr;
    logic [memory_width-1:0] wdata;
  } req_t;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  req_t                    fifo_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              count_q, count_d;
  logic                    resp_valid_q, resp_we_q;
  logic [memory_width-1:0] resp_rdata_q;
  logic [15:0]             stall_cnt_q;

  req_t head;
  logic active, push, pop;

  assign head   = fifo_q[rd_ptr_q];
  assign active = (state_q == ACCESS);
  // Ready depends only on registered occupancy: a full queue never takes a
  // request, even on an edge that also pops.
  assign bus.req_ready = (count_q < 2'd2);
  assign push   = bus.req_valid && bus.req_ready;
  assign pop    = active && !bus.stall;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    state_d = (count_d != 2'd0) ? ACCESS : IDLE;
  end

  assign bus.RE = active && !head.we;
  assign bus.WE = active && head.we;
  assign bus.A  = active ? head.addr  : '0;
  assign bus.WD = active ? head.wdata : '0;

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_we     = resp_we_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.stall_count = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_rdata_q <= '0;
      stall_cnt_q  <= 16'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {bus.req_we, bus.req_addr, bus.req_wdata};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        resp_we_q <= head.we;
        if (!head.we) resp_rdata_q <= bus.RD;
      end
      count_q      <= count_d;
      state_q      <= state_d;
      resp_valid_q <= pop;
      if ((bus.RE || bus.WE) && bus.stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_mem_requester.sv
// Directed bench: stimulus pushes expected responses into a scoreboard queue,
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_mem_requester;
  logic clk = 1'b0;
  logic reset_n;

  mem_requester_if #(.memory_width(32), .memory_depth(1024)) bus ();

  mem_requester #(.memory_width(32), .memory_depth(1024)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic we, input logic [31:0] rdata);
    sb.push_back('{we: we, rdata: rdata});
  endtask

  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (we=%b rdata=%h)",
                 bus.resp_we, bus.resp_rdata);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_we", {63'd0, bus.resp_we}, {63'd0, mon_e.we});
        chk("resp_rdata", {32'd0, bus.resp_rdata}, {32'd0, mon_e.rdata});
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.stall = 1'b0; bus.RD = '0;
    tick(); tick();
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_re_we", {62'd0, bus.RE, bus.WE}, 64'd0);
    chk("rst_a_wd", {22'd0, bus.A, bus.WD}, 64'd0);
    chk("rst_stall_count", {48'd0, bus.stall_count}, 64'd0);
    chk("rst_resp", {31'd0, bus.resp_valid, bus.resp_rdata}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Single load, no stall
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'h005; bus.RD = 32'hDEADBEEF;
    expect_resp(1'b0, 32'hDEADBEEF);
    tick();
    bus.req_valid = 1'b0;
    chk("ld_re", {63'd0, bus.RE}, 64'd1);
    chk("ld_a", {54'd0, bus.A}, 64'd5);
    tick();
    chk("ld_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
    chk("ld_idle_re", {63'd0, bus.RE}, 64'd0);
    tick();

    // Store with 3 stalled cycles; rdata must survive
    bus.stall = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 10'h3FF; bus.req_wdata = 32'h12345678;
    expect_resp(1'b1, 32'hDEADBEEF);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.stall = 1'b0;
      chk("st_hold_we", {63'd0, bus.WE}, 64'd1);
      chk("st_hold_a_wd", {22'd0, bus.A, bus.WD}, {22'd0, 10'h3FF, 32'h12345678});
      if (i < 3) tick();
    end
    tick();
    chk("st_stall_count", {48'd0, bus.stall_count}, 64'd3);
    chk("st_rdata_kept", {32'd0, bus.resp_rdata}, {32'd0, 32'hDEADBEEF});
    tick();

    // Three back-to-back requests against a stalled memory
    bus.stall = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'd1;
    tick();
    chk("b2b_ready_1", {63'd0, bus.req_ready}, 64'd1);
    bus.req_addr = 10'd2;
    tick();
    chk("b2b_ready_full", {63'd0, bus.req_ready}, 64'd0);
    bus.req_addr = 10'd3;
    tick();
    chk("b2b_blocked_ready", {63'd0, bus.req_ready}, 64'd0);
    chk("b2b_head_1", {54'd0, bus.A}, 64'd1);
    bus.stall = 1'b0; bus.RD = 32'h11110001;
    expect_resp(1'b0, 32'h11110001);
    tick();
    bus.stall = 1'b1;
    chk("b2b_head_2", {54'd0, bus.A}, 64'd2);
    chk("b2b_ready_after_pop", {63'd0, bus.req_ready}, 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_third_taken", {63'd0, bus.req_ready}, 64'd0);
    bus.stall = 1'b0; bus.RD = 32'h22220002;
    expect_resp(1'b0, 32'h22220002);
    tick();
    chk("b2b_head_3", {54'd0, bus.A}, 64'd3);
    bus.RD = 32'h33330003;
    expect_resp(1'b0, 32'h33330003);
    tick();
    chk("b2b_idle", {62'd0, bus.RE, bus.WE}, 64'd0);
    tick();

    // Two queued loads drain on consecutive cycles
    bus.stall = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'd7;
    tick();
    bus.req_addr = 10'd8;
    tick();
    bus.req_valid = 1'b0; bus.stall = 1'b0; bus.RD = 32'hAAAA0007;
    expect_resp(1'b0, 32'hAAAA0007);
    tick();
    chk("pair_resp_1", {63'd0, bus.resp_valid}, 64'd1);
    chk("pair_head_2", {54'd0, bus.A}, 64'd8);
    bus.RD = 32'hBBBB0008;
    expect_resp(1'b0, 32'hBBBB0008);
    tick();
    chk("pair_resp_2", {63'd0, bus.resp_valid}, 64'd1);
    tick();
    chk("pair_resp_end", {63'd0, bus.resp_valid}, 64'd0);

    // Reset while two stores are queued behind a stall
    bus.stall = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 10'd9; bus.req_wdata = 32'h0BADF00D;
    tick(); tick();
    bus.req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_re_we", {62'd0, bus.RE, bus.WE}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("mid_rst_stall_count", {48'd0, bus.stall_count}, 64'd0);
    chk("mid_rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
    reset_n = 1'b1;
    tick(); tick(); tick();

    // Saturation of the stall counter
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'd4;
    tick();
    bus.req_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall_count", {48'd0, bus.stall_count}, 64'h0000_0000_0000_FFFF);
    bus.stall = 1'b0; bus.RD = 32'hCAFEF00D;
    expect_resp(1'b0, 32'hCAFEF00D);
    tick();
    chk("sat_no_wrap", {48'd0, bus.stall_count}, 64'h0000_0000_0000_FFFF);
    tick(); tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
